// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save adder tree: reduces num_inputs operands to a sum/carry pair
// through 3:2 compressor levels spread over num_stages valid/ready register stages.
module csa_tree_pipe #(
  parameter int num_inputs  = 8,
  parameter int input_width = 8,
  parameter int num_stages  = 2
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [num_inputs*input_width-1:0]   INPUT,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  output logic [input_width-1:0]              OUT0,
  output logic [input_width-1:0]              OUT1,
  output logic [input_width-1:0]              SUM,
  output logic                                OUT_VALID,
  input  logic                                OUT_READY
);

  localparam int NI = num_inputs;
  localparam int W  = input_width;
  localparam int S  = num_stages;

  typedef logic [NI-1:0][W-1:0] vec_t;

  function automatic int count_levels(input int n);
    int lv;
    int m;
    lv = 0;
    m  = n;
    while (m > 2) begin
      m  = m - m / 3;
      lv = lv + 1;
    end
    return lv;
  endfunction

  localparam int LVL = count_levels(NI);

  // One compressor level on the first n words; results are packed back to the low indices.
  function automatic vec_t csa_level(input vec_t v, input int n);
    vec_t       o;
    int         g;
    logic [W-1:0] a, b, c;
    o = '0;
    g = n / 3;
    for (int i = 0; i < NI; i++) begin
      if (i < g) begin
        a          = v[3*i];
        b          = v[3*i+1];
        c          = v[3*i+2];
        o[2*i]     = a ^ b ^ c;
        o[2*i+1]   = ((a & b) | (a & c) | (b & c)) << 1;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (r < n % 3) o[2*g+r] = v[3*g+r];
    end
    return o;
  endfunction

  function automatic vec_t csa_span(input vec_t v, input int first, input int last);
    vec_t o;
    int   n;
    o = v;
    n = NI;
    for (int k = 0; k < 16; k++) begin
      if (k >= first && k < last) o = csa_level(o, n);
      if (n > 2) n = n - n / 3;
    end
    return o;
  endfunction

  vec_t         r_data [S];
  logic [S-1:0] r_valid;
  vec_t         w_next [S];
  logic [S-1:0] w_load;
  logic [S-1:0] w_up_valid;

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_stage
      localparam int LO = (LVL * gi) / S;
      localparam int HI = (LVL * (gi + 1)) / S;
      if (gi == 0) begin : g_first
        assign w_up_valid[gi] = IN_VALID;
        assign w_next[gi]     = csa_span(vec_t'(INPUT), LO, HI);
      end else begin : g_rest
        assign w_up_valid[gi] = r_valid[gi-1];
        assign w_next[gi]     = csa_span(r_data[gi-1], LO, HI);
      end
    end
  endgenerate

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    w_load        = '0;
    w_load[S-1]   = !r_valid[S-1] || OUT_READY;
    for (int s = S - 2; s >= 0; s--) begin
      w_load[s] = !r_valid[s] || w_load[s+1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid <= '0;
      for (int s = 0; s < S; s++) r_data[s] <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        if (w_load[s]) begin
          r_valid[s] <= w_up_valid[s];
          if (w_up_valid[s]) r_data[s] <= w_next[s];
        end
      end
    end
  end

  assign OUT0 = r_data[S-1][0];
  generate
    if (NI >= 2) begin : g_out1
      assign OUT1 = r_data[S-1][1];
    end else begin : g_out1_zero
      assign OUT1 = '0;
    end
  endgenerate

  assign SUM       = OUT0 + OUT1;
  assign OUT_VALID = r_valid[S-1];
  assign IN_READY  = w_load[0];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: vector table, back-pressure, streaming,
// mid-flight reset, and a small parameter sweep on extra instances.
module tb_csa_tree_pipe;

  logic        CLK;
  logic        RST_N;
  logic        sw_rst_n;
  logic [63:0] INPUT;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  OUT0;
  logic [7:0]  OUT1;
  logic [7:0]  SUM;
  logic        OUT_VALID;
  logic        OUT_READY;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [7:0] q[$];

  csa_tree_pipe #(.num_inputs(8), .input_width(8), .num_stages(2)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .INPUT(INPUT), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT0(OUT0), .OUT1(OUT1), .SUM(SUM), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_sum(input logic [63:0] v);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 8; k++) s = s + v[k*8 +: 8];
    return s;
  endfunction

  // Scoreboard monitor: pops on delivery, pushes on accept, checks hold during stalls.
  initial begin
    logic       stall_prev;
    logic [7:0] h0, h1, hs, e, t;
    stall_prev = 1'b0;
    h0 = '0; h1 = '0; hs = '0;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (stall_prev) begin
          chk("hold_valid", OUT_VALID, 1);
          chk("hold_out0", OUT0, h0);
          chk("hold_out1", OUT1, h1);
          chk("hold_sum", SUM, hs);
        end
        stall_prev = OUT_VALID && !OUT_READY;
        h0 = OUT0; h1 = OUT1; hs = SUM;
        if (OUT_VALID && OUT_READY) begin
          if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected actual=%0h required=none", SUM);
          end else begin
            e = q.pop_front();
            t = OUT0 + OUT1;
            chk("sb_sum", SUM, e);
            chk("sb_csa", t, e);
            $display("out sum=%02h", SUM);
          end
          n_out++;
        end
        if (IN_VALID && IN_READY) q.push_back(model_sum(INPUT));
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Parameter sweep instances, each self-driven with OUT_READY held high.
  function automatic int sw_ni(input int i);
    case (i) 0: return 1; 1: return 2; 2: return 3; default: return 17; endcase
  endfunction
  function automatic int sw_w(input int i);
    case (i) 0: return 1; 3: return 1; default: return 13; endcase
  endfunction
  function automatic int sw_s(input int i);
    case (i) 1: return 1; 3: return 1; default: return 4; endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sw
      localparam int NI = sw_ni(gi);
      localparam int W  = sw_w(gi);
      localparam int S  = sw_s(gi);
      logic [NI*W-1:0] in_d;
      logic            iv, ir, ov, ordy;
      logic [W-1:0]    o0, o1, sm;
      logic [W-1:0]    exp_s, e0, e1, t;
      logic            done;
      int              lat;

      csa_tree_pipe #(.num_inputs(NI), .input_width(W), .num_stages(S)) u_sw (
        .CLK(CLK), .RST_N(sw_rst_n), .INPUT(in_d), .IN_VALID(iv), .IN_READY(ir),
        .OUT0(o0), .OUT1(o1), .SUM(sm), .OUT_VALID(ov), .OUT_READY(ordy)
      );

      initial begin
        done = 1'b0; iv = 1'b0; ordy = 1'b1; in_d = '0;
        exp_s = '0; e0 = '0; e1 = '0; lat = 0;
        @(posedge sw_rst_n);
        for (int v = 0; v < 4; v++) begin
          @(posedge CLK); #2;
          for (int k = 0; k < NI; k++) in_d[k*W +: W] = W'($urandom);
          exp_s = '0;
          for (int k = 0; k < NI; k++) exp_s = exp_s + in_d[k*W +: W];
          e0 = in_d[W-1:0];
          e1 = W'(in_d >> W);
          iv = 1'b1;
          @(posedge CLK); #1;
          iv = 1'b0;
          lat = 1;
          while (!ov && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
          end
          t = o0 + o1;
          chk($sformatf("sw%0d_lat", gi), lat, S);
          chk($sformatf("sw%0d_sum", gi), sm, exp_s);
          chk($sformatf("sw%0d_csa", gi), t, exp_s);
          $display("sweep%0d ni=%0d w=%0d s=%0d sum=%0h lat=%0d", gi, NI, W, S, sm, lat);
        end
        done = 1'b1;
      end

      if (NI <= 2) begin : g_pass
        initial forever begin
          @(negedge CLK);
          if (ov && sw_rst_n) begin
            chk($sformatf("sw%0d_out0_pass", gi), o0, e0);
            chk($sformatf("sw%0d_out1_pass", gi), o1, e1);
          end
        end
      end
    end
  endgenerate

  typedef struct {
    logic [63:0] ops;
    logic [7:0]  exp_sum;
  } vec_rec_t;

  task automatic send_and_time(input logic [63:0] ops, output int lat);
    INPUT = ops;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    INPUT = {$urandom, $urandom};
    lat = 1;
    while (!OUT_VALID && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t    tbl [8];
    int          lat, sent, acc_cnt, base, cyc;
    logic        acc;
    logic [63:0] bp_set [5];

    tbl[0] = '{64'h0807060504030201, 8'h24};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 8'hF8};
    tbl[2] = '{64'h0000000000000000, 8'h00};
    tbl[3] = '{64'h8080808080808080, 8'h00};
    tbl[4] = '{64'h8070605040302010, 8'h40};
    tbl[5] = '{64'hAAAAAAAA55555555, 8'hFC};
    tbl[6] = '{64'h00000000000000FF, 8'hFF};
    tbl[7] = '{64'h0101010101010101, 8'h08};

    RST_N = 1'b0; sw_rst_n = 1'b0;
    IN_VALID = 1'b0; INPUT = '0; OUT_READY = 1'b1;
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out0", OUT0, 0);
    chk("rst_out1", OUT1, 0);
    chk("rst_sum", SUM, 0);
    @(posedge CLK); @(posedge CLK); #2;
    RST_N = 1'b1; sw_rst_n = 1'b1;
    #1;
    chk("rst_in_ready", IN_READY, 1);
    @(posedge CLK); #2;

    for (int i = 0; i < 8; i++) begin
      send_and_time(tbl[i].ops, lat);
      chk($sformatf("tbl%0d_sum", i), SUM, tbl[i].exp_sum);
      chk($sformatf("tbl%0d_lat", i), lat, 2);
      $display("vec %0d ops=%016h sum=%02h lat=%0d", i, tbl[i].ops, SUM, lat);
      @(posedge CLK); #2;
    end

    // Back-pressure: five sets offered back to back, consumer stalled for four cycles.
    for (int i = 0; i < 5; i++) bp_set[i] = {$urandom, $urandom};
    OUT_READY = 1'b0;
    sent = 0;
    for (cyc = 0; cyc < 40 && sent < 5; cyc++) begin
      if (cyc == 4) OUT_READY = 1'b1;
      INPUT = bp_set[sent];
      IN_VALID = 1'b1;
      #4;
      acc = IN_READY;
      if (cyc < 4) chk($sformatf("bp_ready_c%0d", cyc), IN_READY, (cyc < 2) ? 1 : 0);
      @(posedge CLK); #2;
      if (acc) sent++;
    end
    IN_VALID = 1'b0;
    chk("bp_sent", sent, 5);
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(posedge CLK); #2;
      cyc++;
    end
    chk("bp_drained", q.size(), 0);

    // Streaming: 100 back-to-back sets with the consumer always ready.
    OUT_READY = 1'b1;
    base = n_out;
    acc_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      INPUT = {$urandom, $urandom};
      IN_VALID = 1'b1;
      #4;
      if (IN_READY) acc_cnt++;
      @(posedge CLK); #2;
    end
    IN_VALID = 1'b0;
    chk("stream_accepts", acc_cnt, 100);
    @(posedge CLK);
    @(negedge CLK); #1;
    chk("stream_results", n_out - base, 100);
    @(posedge CLK); #2;

    cyc = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done)
           && cyc < 1000) begin
      @(posedge CLK); #2;
      cyc++;
    end
    chk("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done && g_sw[4].done, 1);

    // Reset with two results in flight.
    INPUT = {$urandom, $urandom};
    IN_VALID = 1'b1;
    @(posedge CLK); #2;
    INPUT = {$urandom, $urandom};
    @(posedge CLK); #2;
    IN_VALID = 1'b0;
    chk("rst_inflight_valid", OUT_VALID, 1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_valid", OUT_VALID, 0);
    chk("rst_mid_out0", OUT0, 0);
    chk("rst_mid_out1", OUT1, 0);
    chk("rst_mid_sum", SUM, 0);
    q.delete();
    @(posedge CLK); @(posedge CLK); #2;
    RST_N = 1'b1;
    #1;
    chk("rst_rel_in_ready", IN_READY, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("rst_no_stale_c%0d", c), OUT_VALID, 0);
    end
    @(posedge CLK); #2;
    send_and_time(tbl[0].ops, lat);
    chk("post_rst_sum", SUM, tbl[0].exp_sum);
    chk("post_rst_lat", lat, 2);
    @(posedge CLK); #2;
    @(posedge CLK); #2;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csa_tree_pipe.md
CSA_TREE_PIPE -- requirements
Module: csa_tree_pipe

Interface
REQ-001 SHALL have parameter num_inputs, default 8: number of addend operands, legal range 1..64.
REQ-002 SHALL have parameter input_width, default 8: width of each operand and each output, legal range 1..64.
REQ-003 SHALL have parameter num_stages, default 2: register stages between input and output, legal range 1..8.
REQ-004 SHALL have port CLK, input, 1: single clock, all flops rising-edge.
REQ-005 SHALL have port RST_N, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port INPUT, input, num_inputs*input_width: packed operands, operand k = INPUT[k*input_width +: input_width].
REQ-007 SHALL have port IN_VALID, input, 1: INPUT carries an operand set.
REQ-008 SHALL have port IN_READY, output, 1: block can accept this cycle.
REQ-009 SHALL have port OUT0, output, input_width: carry-save partial sum.
REQ-010 SHALL have port OUT1, output, input_width: carry-save partial carry, pre-shifted to its true weight.
REQ-011 SHALL have port SUM, output, input_width: OUT0+OUT1 mod 2^input_width.
REQ-012 SHALL have port OUT_VALID, output, 1: OUT0/OUT1/SUM hold a result.
REQ-013 SHALL have port OUT_READY, input, 1: consumer takes the result this cycle.

Function
REQ-014 SHALL accept a transfer on a rising edge when IN_VALID && IN_READY, and SHALL deliver it on a rising edge when OUT_VALID && OUT_READY.
REQ-015 SHALL guarantee (OUT0 + OUT1) mod 2^input_width == (sum of all num_inputs operands) mod 2^input_width; carries beyond the MSB are discarded.
REQ-016 SHALL reduce operands with 3:2 full-adder compressor levels, distributing levels across num_stages register stages; the per-stage split is implementation-defined, and only REQ-015 is checked.
REQ-017 SHALL produce OUT0 = operand 0, OUT1 = 0 when num_inputs == 1; OUT0 = operand 0, OUT1 = operand 1 when num_inputs == 2.
REQ-018 SHALL keep one valid bit per stage and advance stage s when stage s+1 is empty or is draining this cycle; the last stage drains on OUT_READY.
REQ-019 SHALL drive IN_READY = !valid[1] || stage 1 advances this cycle; IN_READY SHALL NOT depend combinationally on IN_VALID.
REQ-020 SHALL have latency num_stages cycles from accept edge to OUT_VALID high when unstalled, and SHALL sustain throughput of one result per cycle with OUT_READY held high.
REQ-021 SHALL hold OUT0, OUT1, SUM stable and OUT_VALID high while OUT_VALID && !OUT_READY.
REQ-022 SHALL preserve order and never drop or duplicate a result; a full pipeline with OUT_READY low SHALL deassert IN_READY.
REQ-023 SHALL allow accept and drain on the same edge when full, with no bubble inserted.
REQ-024 SHALL compute SUM combinationally from registered OUT0/OUT1.
REQ-025 SHALL ignore INPUT when IN_VALID is low, with no state change from it.

Reset
REQ-026 SHALL, on RST_N low, asynchronously clear all stage valid bits and all data registers to 0: OUT0 = OUT1 = SUM = 0, OUT_VALID = 0.
REQ-027 SHALL drive IN_READY = 1 in the first cycle after RST_N deasserts.
REQ-028 SHALL discard all in-flight results on reset assertion mid-operation, with no partial output afterwards.
REQ-029 SHALL sample RST_N deassertion synchronously to CLK; reset SHALL be held for at least one CLK edge.

Verification
REQ-030 SHALL include a basic scenario: defaults, operands 1..8, OUT_READY=1 -> OUT_VALID after 2 cycles, SUM = 36 (0x24).
REQ-031 SHALL include an overflow scenario: defaults, all operands 0xFF -> SUM = 0xF8 (2040 mod 256).
REQ-032 SHALL include a back-pressure scenario: 5 back-to-back sets, OUT_READY low for 4 cycles -> IN_READY falls once the pipeline is full, outputs stay stable, and all 5 SUMs emerge in order with none lost.
REQ-033 SHALL include a streaming scenario: random data, OUT_READY=1, IN_VALID=1 for 100 cycles -> 100 results at 1/cycle, each satisfying REQ-015.
REQ-034 SHALL include a reset-mid-flight scenario: assert RST_N low with 2 results in flight -> OUT_VALID=0 and OUT0=OUT1=0 immediately, and no stale output after release.
REQ-035 SHALL include a parameter sweep: num_inputs in {1,2,3,17}, input_width in {1,13}, num_stages in {1,4} -> REQ-015 and REQ-017 hold, and latency equals num_stages.
